// File: rtl/countdown_sequencer.sv
// Countdown sequencer: turns (duration, repeat) commands into back-to-back timer runs
// and reports per-interval, end-of-sequence and abort events to the control logic.
module countdown_sequencer #(
    parameter int WIDTH  = 8,
    parameter int CWIDTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clkena,
    input  logic [WIDTH-1:0]  cmd_time,
    input  logic [CWIDTH-1:0] cmd_count,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              abort,
    output logic [WIDTH-1:0]  cd_time,
    output logic              cd_run,
    output logic              cd_abort,
    input  logic              cd_done,
    output logic              stat_busy,
    output logic [CWIDTH-1:0] stat_remain,
    output logic              evt_period,
    output logic              evt_last,
    output logic              evt_abort
);

    // state   | meaning
    // ST_IDLE | no sequence; cmd_ready high
    // ST_RUN  | cd_run held until the timer samples it on a clkena cycle
    // ST_WAIT | interval in progress; waiting for cd_done
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   time_q, time_d;
    logic [CWIDTH-1:0]  remain_q, remain_d;
    logic               run_q, run_d;
    logic               per_q, per_d;
    logic               last_q, last_d;
    logic               abt_q, abt_d;

    // Combinational so the timer drops its interval in the same cycle
    assign cd_abort = abort && (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        time_d   = time_q;
        remain_d = remain_q;
        run_d    = run_q;
        per_d    = 1'b0;
        last_d   = 1'b0;
        abt_d    = 1'b0;
        if (cd_abort) begin
            state_d  = ST_IDLE;
            run_d    = 1'b0;
            remain_d = '0;
            abt_d    = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        time_d   = cmd_time;
                        remain_d = (cmd_count == '0) ? CWIDTH'(1) : cmd_count;
                        run_d    = 1'b1;
                        state_d  = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (clkena) begin
                        run_d   = 1'b0;
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cd_done) begin
                        per_d = 1'b1;
                        if (remain_q != '0) begin
                            remain_d = remain_q - CWIDTH'(1);
                        end
                        if (remain_q <= CWIDTH'(1)) begin
                            last_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            // Re-arm immediately so intervals run back-to-back
                            run_d   = 1'b1;
                            state_d = ST_RUN;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    run_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            time_q   <= '0;
            remain_q <= '0;
            run_q    <= 1'b0;
            per_q    <= 1'b0;
            last_q   <= 1'b0;
            abt_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            time_q   <= time_d;
            remain_q <= remain_d;
            run_q    <= run_d;
            per_q    <= per_d;
            last_q   <= last_d;
            abt_q    <= abt_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign stat_busy   = (state_q != ST_IDLE);
    assign cd_time     = time_q;
    assign cd_run      = run_q;
    assign stat_remain = remain_q;
    assign evt_period  = per_q;
    assign evt_last    = last_q;
    assign evt_abort   = abt_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer: behavioural timer + sequence model checked every cycle,
// plus directed scenarios with literal timing and event-count expectations.
module tb_countdown_sequencer;
    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clkena = 1'b1;
    logic [W-1:0]  cmd_time = '0;
    logic [CW-1:0] cmd_count = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          abort = 1'b0;
    logic [W-1:0]  cd_time;
    logic          cd_run;
    logic          cd_abort;
    logic          cd_done;
    logic          stat_busy;
    logic [CW-1:0] stat_remain;
    logic          evt_period, evt_last, evt_abort;

    countdown_sequencer #(.WIDTH(W), .CWIDTH(CW)) dut (
        .clk(clk), .reset(rst_n), .clkena(clkena),
        .cmd_time(cmd_time), .cmd_count(cmd_count), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .abort(abort), .cd_time(cd_time), .cd_run(cd_run), .cd_abort(cd_abort), .cd_done(cd_done),
        .stat_busy(stat_busy), .stat_remain(stat_remain),
        .evt_period(evt_period), .evt_last(evt_last), .evt_abort(evt_abort)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic ena_div = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        clkena = ena_div ? (cyc % 3 == 0) : 1'b1;
    end

    // Timer stand-in: loads on a sampled run, done one enabled cycle after the count expires
    logic          t_act;
    logic [W-1:0]  t_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_act <= 1'b0; t_cnt <= '0; cd_done <= 1'b0;
        end else begin
            cd_done <= 1'b0;
            if (cd_abort) t_act <= 1'b0;
            else if (clkena) begin
                if (t_act) begin
                    if (t_cnt <= W'(1)) begin cd_done <= 1'b1; t_act <= 1'b0; end
                    else t_cnt <= t_cnt - W'(1);
                end else if (cd_run) begin
                    t_act <= 1'b1; t_cnt <= cd_time;
                end
            end
        end
    end

    // Sequence model: a sequence is "busy" with a number of intervals left; each interval
    // first needs its run request seen under clkena, then one timer completion.
    logic          m_busy, m_run, m_per, m_last, m_abt;
    logic [CW-1:0] m_remain;
    logic [W-1:0]  m_time;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_run <= 1'b0; m_remain <= '0; m_time <= '0;
            m_per <= 1'b0; m_last <= 1'b0; m_abt <= 1'b0;
        end else begin
            m_per <= 1'b0; m_last <= 1'b0; m_abt <= 1'b0;
            if (!m_busy) begin
                if (cmd_valid) begin
                    m_time <= cmd_time;
                    m_remain <= (cmd_count == '0) ? CW'(1) : cmd_count;
                    m_busy <= 1'b1; m_run <= 1'b1;
                end
            end else if (abort) begin
                m_busy <= 1'b0; m_run <= 1'b0; m_remain <= '0; m_abt <= 1'b1;
            end else if (m_run) begin
                if (clkena) m_run <= 1'b0;
            end else if (cd_done) begin
                m_per <= 1'b1;
                m_remain <= m_remain - CW'(1);
                if (m_remain == CW'(1)) begin m_last <= 1'b1; m_busy <= 1'b0; end
                else m_run <= 1'b1;
            end
        end
    end

    int run_cyc = 0;
    int n_period = 0, n_last = 0, n_abort = 0;
    int evt_q[$];
    logic prev_run = 1'b0;

    always @(negedge clk) begin
        check("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
        check("stat_busy", 32'(stat_busy), 32'(m_busy));
        check("cd_run", 32'(cd_run), 32'(m_run));
        check("cd_time", 32'(cd_time), 32'(m_time));
        check("cd_abort", 32'(cd_abort), 32'(abort && m_busy));
        check("stat_remain", 32'(stat_remain), 32'(m_remain));
        check("evt_period", 32'(evt_period), 32'(m_per));
        check("evt_last", 32'(evt_last), 32'(m_last));
        check("evt_abort", 32'(evt_abort), 32'(m_abt));
        if (cd_run && !prev_run) run_cyc = cyc;
        prev_run = cd_run;
        if (evt_period) begin n_period++; evt_q.push_back(cyc); end
        if (evt_last) n_last++;
        if (evt_abort) n_abort++;
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic send(input logic [W-1:0] t, input logic [CW-1:0] c);
        int n = 0;
        cmd_time = t; cmd_count = c; cmd_valid = 1'b1;
        while (!cmd_ready && n < 500) begin step(); n++; end
        if (!cmd_ready) check("send_timeout", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (stat_busy && n < 500) begin step(); n++; end
        check("idle_timeout", 32'(stat_busy), 32'd0);
        step();
    endtask

    int lp, la, lb, n;

    initial begin
        repeat (3) step();
        check("reset_ready", 32'(cmd_ready), 32'd1);
        check("reset_outputs", 32'({cd_time, cd_run, cd_abort, stat_busy, stat_remain,
                                    evt_period, evt_last, evt_abort}), 32'd0);
        rst_n = 1'b1;
        step();

        // 1: single interval of 3
        evt_q.delete(); lp = n_period; la = n_last;
        send(8'd3, 4'd1);
        wait_idle();
        check("t1_run_to_evt", 32'(evt_q[0] - run_cyc), 32'd5);
        check("t1_last", 32'(n_last - la), 32'd1);
        check("t1_remain", 32'(stat_remain), 32'd0);
        check("t1_ready", 32'(cmd_ready), 32'd1);

        // 2: three intervals of 2
        evt_q.delete(); lp = n_period; la = n_last;
        send(8'd2, 4'd3);
        wait_idle();
        check("t2_periods", 32'(n_period - lp), 32'd3);
        check("t2_last", 32'(n_last - la), 32'd1);
        check("t2_gap1", 32'(evt_q[1] - evt_q[0]), 32'd4);
        check("t2_gap2", 32'(evt_q[2] - evt_q[1]), 32'd4);

        // 3: zero-length intervals
        lp = n_period; la = n_last;
        send(8'd0, 4'd2);
        wait_idle();
        check("t3_periods", 32'(n_period - lp), 32'd2);
        check("t3_last", 32'(n_last - la), 32'd1);

        // 4: clkena 1-of-3
        ena_div = 1'b1;
        lp = n_period; la = n_last;
        send(8'd2, 4'd1);
        wait_idle();
        check("t4_periods", 32'(n_period - lp), 32'd1);
        check("t4_last", 32'(n_last - la), 32'd1);
        ena_div = 1'b0;
        step();

        // 5: abort during second interval, then immediate new command
        lp = n_period; la = n_last; lb = n_abort;
        send(8'd10, 4'd4);
        n = 0;
        while (n_period == lp && n < 500) begin step(); n++; end
        check("t5_first_period", 32'(n_period - lp), 32'd1);
        repeat (3) step();
        abort = 1'b1;
        #1 check("t5_cd_abort", 32'(cd_abort), 32'd1);
        @(posedge clk); #2;
        abort = 1'b0;
        check("t5_evt_abort", 32'(evt_abort), 32'd1);
        check("t5_remain", 32'(stat_remain), 32'd0);
        check("t5_ready", 32'(cmd_ready), 32'd1);
        send(8'd5, 4'd1);
        check("t5_new_busy", 32'(stat_busy), 32'd1);
        check("t5_new_time", 32'(cd_time), 32'd5);
        wait_idle();
        check("t5_last", 32'(n_last - la), 32'd1);
        check("t5_aborts", 32'(n_abort - lb), 32'd1);

        // count 0 behaves as 1
        la = n_last;
        send(8'd1, 4'd0);
        wait_idle();
        check("t7_count0_last", 32'(n_last - la), 32'd1);

        // abort while idle is ignored
        lb = n_abort;
        abort = 1'b1; step(); abort = 1'b0; step();
        check("idle_abort", 32'(n_abort - lb), 32'd0);

        // 6: reset in WAIT
        lp = n_period; la = n_last; lb = n_abort;
        send(8'd10, 4'd5);
        n = 0;
        while (!(stat_busy && !cd_run) && n < 100) begin step(); n++; end
        check("t6_in_wait", 32'({stat_busy, cd_run}), 32'd2);
        step();
        rst_n = 1'b0;
        #1 check("t6_reset_outputs", 32'({cd_time, cd_run, cd_abort, stat_busy, stat_remain,
                                           evt_period, evt_last, evt_abort}), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        check("t6_ready", 32'(cmd_ready), 32'd1);
        repeat (20) step();
        check("t6_no_events", 32'((n_period - lp) + (n_last - la) + (n_abort - lb)), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/countdown_sequencer.md
Name: countdown_sequencer

Overview:
- Upstream command stage for the countdown timer. Accepts interval commands (duration plus repeat count) over a valid/ready stream.
- Drives the timer's ctrl_time/ctrl_run/ctrl_abort and consumes its stat_done to run the interval the requested number of times back-to-back.
- Emits per-interval and end-of-sequence event pulses to the control logic above it.

Parameters:
- WIDTH, 8: interval width; equals the timer's WIDTH.
- CWIDTH, 4: repeat-count width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-low (asserted at 0)
- clkena  in  1  clock enable shared with the timer
- cmd_time  in  WIDTH  interval duration in clkena cycles
- cmd_count  in  CWIDTH  repetitions; 0 is treated as 1
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can take a command
- abort  in  1  cancel the current sequence
- cd_time  out  WIDTH  to timer ctrl_time
- cd_run  out  1  to timer ctrl_run
- cd_abort  out  1  to timer ctrl_abort
- cd_done  in  1  from timer stat_done
- stat_busy  out  1  sequence in progress
- stat_remain  out  CWIDTH  intervals still to finish, including the current one
- evt_period  out  1  one-cycle pulse per finished interval
- evt_last  out  1  one-cycle pulse on the final interval, coincident with evt_period
- evt_abort  out  1  one-cycle pulse when a sequence is aborted

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - cd_time=0, cd_run=0, cd_abort=0.
  - stat_busy=0, stat_remain=0.
  - evt_period=0, evt_last=0, evt_abort=0.
  - Reset mid-sequence discards the sequence silently; no event pulses.
- cmd_ready=1 exactly when FSM is IDLE.
- Handshake:
  - A command is accepted on a cycle with cmd_valid & cmd_ready, regardless of clkena.
  - On accept: cd_time<=cmd_time; stat_remain<=max(cmd_count,1); FSM->RUN.
- FSM states: IDLE, RUN, WAIT. All outputs are registered except cd_abort.
- RUN:
  - cd_run=1.
  - Stays in RUN until a cycle with clkena=1, because the timer samples run only under clkena. Then FSM->WAIT and cd_run<=0.
  - cd_run is therefore high for at least one clkena-qualified cycle.
- WAIT:
  - Waits for cd_done=1; clkena is not required, since the timer already qualifies done.
  - On cd_done, next cycle evt_period=1 and stat_remain decrements.
  - If stat_remain was 1: evt_last=1 with evt_period, FSM->IDLE.
  - Otherwise FSM->RUN. The next cd_run is issued immediately, with no gap cycle.
- cmd_time=0: the timer answers done one clkena cycle after run with no busy phase. WAIT handles this unchanged.
- stat_busy=1 in RUN and WAIT.
- Abort:
  - cd_abort = abort & (FSM!=IDLE), combinational, so the timer sees it the same cycle.
  - Next cycle: FSM->IDLE, stat_remain=0, cd_run=0, evt_abort=1.
  - Abort in IDLE is ignored; no pulse.
- Simultaneous events:
  - abort and cd_done in the same WAIT cycle: abort wins. No evt_period/evt_last; evt_abort=1.
  - abort in RUN: the interval never starts; evt_abort=1.
  - Command offered while busy is held off by cmd_ready=0 and must stay valid until accepted.
- Arithmetic:
  - stat_remain is unsigned, decrements by 1 per finished interval and never wraps below 0.
  - Maximum sequence length is 2^CWIDTH-1 intervals.

Test Plan:
1. clkena=1, command time=3 count=1 -> cd_run one cycle; done 4 cycles after run; one cycle later evt_period=evt_last=1, stat_remain 1->0, cmd_ready=1.
2. time=2 count=3 -> three evt_period pulses spaced 4 cycles apart; evt_last only with the third; stat_remain 3,2,1,0.
3. time=0 count=2 -> two intervals complete with zero-length timer phases; evt_last on the second.
4. clkena toggling 1-of-3, time=2 count=1 -> cd_run held until a clkena cycle; evt_period arrives after 2 enabled decrements.
5. time=10 count=4, abort during the second interval -> cd_abort high the same cycle; evt_abort next cycle; stat_remain=0; no evt_last; a new command is accepted the following cycle.
6. reset driven low in WAIT with count=5 -> all outputs 0 immediately; cmd_ready=1 after release; no events.
